// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential shift-and-add-3 binary-to-BCD converter, one conversion per start.
// Define BIN_TO_BCD_BLANK_EN to replace leading zero digits on bcd_o with 4'hF.
module bin_to_bcd #(
   parameter int unsigned BIN_W  = 10,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [BIN_W-1:0]      bin_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  overflow_o
);
   localparam int unsigned ACC_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
`ifdef BIN_TO_BCD_BLANK_EN
   localparam logic [ACC_W-1:0] BCD_RST = {ACC_W{1'b1}} << 4;
`else
   localparam logic [ACC_W-1:0] BCD_RST = '0;
`endif

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d, step_bin;
   logic [ACC_W-1:0]   acc_q, acc_d, adj, step_acc;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d, carry;
   logic [ACC_W-1:0]   bcd_d;
   logic               overflow_d, valid_d;

   function automatic logic [ACC_W-1:0] blank(input logic [ACC_W-1:0] d);
      logic [ACC_W-1:0] r;
`ifdef BIN_TO_BCD_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      r = d;
`ifdef BIN_TO_BCD_BLANK_EN
      // Walk from the top digit down; digit 0 is never blanked.
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         lead = lead & (d[4*i +: 4] == 4'd0);
         if (lead) r[4*i +: 4] = 4'hF;
      end
`endif
      return r;
   endfunction

   always_comb begin
      adj = acc_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   assign carry    = adj[ACC_W-1];
   assign step_acc = {adj[ACC_W-2:0], bin_q[BIN_W-1]};
   assign step_bin = bin_q << 1;
   assign busy_o   = (state_q == SHIFT);

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_o;
      overflow_d = overflow_o;
      valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               bin_d   = bin_i;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = CNT_W'(BIN_W);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = step_acc;
            bin_d = step_bin;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d      = blank(step_acc);
               overflow_d = ovf_q | carry;
               valid_d    = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         bcd_o      <= BCD_RST;
         overflow_o <= 1'b0;
         valid_o    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         bcd_o      <= bcd_d;
         overflow_o <= overflow_d;
         valid_o    <= valid_d;
      end
   end
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: randomized self-checking bench for bin_to_bcd (4-digit and 3-digit instances)
// against an arithmetic decimal model; honours BIN_TO_BCD_BLANK_EN.
module tb_bin_to_bcd;
   logic        clk = 1'b0;
   logic        rstn, start, sel;
   logic [9:0]  bin;
   logic        busy_a, valid_a, ovf_a;
   logic [15:0] bcd_a;
   logic        busy_b, valid_b, ovf_b;
   logic [11:0] bcd_b;
   logic        busy_s, valid_s, ovf_s;
   logic [15:0] bcd_s;
   logic [15:0] prev_bcd [2];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   bin_to_bcd #(.BIN_W(10), .DIGITS(4)) dut_a (
      .clk_i(clk), .rstn_i(rstn), .bin_i(bin), .start_i(start && !sel),
      .busy_o(busy_a), .valid_o(valid_a), .bcd_o(bcd_a), .overflow_o(ovf_a));

   bin_to_bcd #(.BIN_W(10), .DIGITS(3)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .bin_i(bin), .start_i(start && sel),
      .busy_o(busy_b), .valid_o(valid_b), .bcd_o(bcd_b), .overflow_o(ovf_b));

   always_comb begin
      busy_s  = sel ? busy_b  : busy_a;
      valid_s = sel ? valid_b : valid_a;
      ovf_s   = sel ? ovf_b   : ovf_a;
      bcd_s   = sel ? {4'h0, bcd_b} : bcd_a;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Decimal digits of v mod 10^digits; leading digits blanked when enabled.
   function automatic logic [15:0] model_bcd(input int unsigned v, input int unsigned digits);
      logic [15:0] r;
      int unsigned m, dg;
      r = '0;
      m = v % pow10(digits);
      for (int unsigned i = 0; i < digits; i++) begin
         dg = (m / pow10(i)) % 10;
`ifdef BIN_TO_BCD_BLANK_EN
         if (i > 0 && m < pow10(i)) dg = 15;
`endif
         r[4*i +: 4] = dg[3:0];
      end
      return r;
   endfunction

   task automatic convert(input logic s, input int unsigned v);
      int unsigned lat, digits;
      logic [15:0] eb;
      logic        eo;
      sel    = s;
      digits = s ? 3 : 4;
      eb     = model_bcd(v, digits);
      eo     = (v >= pow10(digits));
      @(negedge clk);
      bin   = v[9:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!valid_s && lat < 20) begin
         check("busy", busy_s, 1'b1);
         check("hold_bcd", bcd_s, prev_bcd[s]);
         bin = 10'($urandom);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 10);
      check("bcd", bcd_s, eb);
      check("overflow", ovf_s, eo);
      check("busy_valid_overlap", busy_s, 1'b0);
      prev_bcd[s] = eb;
      @(negedge clk);
      check("valid_drop", valid_s, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned lat, nval;
      rstn  = 1'b0;
      start = 1'b0;
      sel   = 1'b0;
      bin   = '0;
      prev_bcd[0] = model_bcd(0, 4);
      prev_bcd[1] = model_bcd(0, 3);
      repeat (3) @(negedge clk);
      check("rst_busy", busy_a, 1'b0);
      check("rst_valid", valid_a, 1'b0);
      check("rst_ovf", ovf_a, 1'b0);
      check("rst_bcd_a", bcd_a, prev_bcd[0]);
      check("rst_bcd_b", {4'h0, bcd_b}, prev_bcd[1]);
      rstn = 1'b1;

      convert(1'b0, 0);
      convert(1'b0, 1023);
      convert(1'b0, 255);
      convert(1'b1, 1000);
      convert(1'b1, 999);

      // start held high; bin_i changes mid-conversion only affect the next acceptance
      sel = 1'b0;
      @(negedge clk);
      bin   = 10'd37;
      start = 1'b1;
      @(negedge clk);
      lat  = 0;
      nval = 0;
      while (nval < 2 && lat < 40) begin
         if (lat == 5) bin = 10'd512;
         if (valid_s) begin
            check("b2b_overlap", busy_s, 1'b0);
            if (nval == 0) begin
               check("b2b_lat1", lat, 10);
               check("b2b_bcd1", bcd_s, model_bcd(37, 4));
            end else begin
               check("b2b_lat2", lat, 21);
               check("b2b_bcd2", bcd_s, model_bcd(512, 4));
               start = 1'b0;
            end
            nval++;
         end else begin
            check("b2b_busy", busy_s, 1'b1);
         end
         if (nval < 2) begin
            @(negedge clk);
            lat++;
         end
      end
      check("b2b_count", nval, 2);
      prev_bcd[0] = model_bcd(512, 4);
      @(negedge clk);
      check("b2b_idle", busy_s, 1'b0);

      // reset 5 cycles into a conversion
      @(negedge clk);
      bin   = 10'd1023;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      #1;
      prev_bcd[0] = model_bcd(0, 4);
      prev_bcd[1] = model_bcd(0, 3);
      check("abort_busy", busy_a, 1'b0);
      check("abort_valid", valid_a, 1'b0);
      check("abort_ovf", ovf_a, 1'b0);
      check("abort_bcd", bcd_a, prev_bcd[0]);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_valid", valid_a, 1'b0);
      end
      convert(1'b0, 42);

      for (int unsigned v = 0; v < 1024; v++) convert(1'b0, v);
      for (int i = 0; i < 300; i++) convert(1'b1, $urandom_range(0, 1023));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
